// File: rtl/tile_noc_pkg.sv
// Shared flit definitions for the tile request mesh routers.
// Widths, flit layout, dimension encodings and the routing coordinate helper.
package tile_noc_pkg;

    localparam int NOC_DATA_W  = 592;
    localparam int NOC_ADDR_W  = 37;
    localparam int NOC_SZ_W    = 42;
    localparam int NOC_COORD_W = 2;
    localparam int NOC_FLIT_W  = NOC_DATA_W + NOC_ADDR_W + NOC_SZ_W + 1;

    typedef enum logic {
        DIM_X = 1'b0,
        DIM_Y = 1'b1
    } dim_e;

    typedef struct packed {
        logic [NOC_DATA_W-1:0] data;
        logic [NOC_ADDR_W-1:0] addr;
        logic [NOC_SZ_W-1:0]   sz;
        logic                  expun;
    } flit_t;

    function automatic logic [NOC_COORD_W-1:0] flit_dest(flit_t f, dim_e dim);
        return (dim == DIM_Y) ? f.addr[NOC_COORD_W +: NOC_COORD_W]
                              : f.addr[0 +: NOC_COORD_W];
    endfunction

endpackage

// File: rtl/tile_lane_fifo.sv
// Circular FIFO used for router pass and eject queues.
// Ports: push/din write, pop read, head = oldest entry, count/full/empty status.
module tile_lane_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             wr;
    logic             rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd    = pop && !empty;
    // a pop frees the slot, so a full FIFO still takes a same-cycle write
    assign wr    = push && (!full || rd);
    assign head  = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end

endmodule

// File: rtl/tile_dim_router_fifo.sv
// One-dimension router stage: two opposing lanes with pass/eject FIFOs,
// starvation-bounded local injection, round-robin eject and credit stops.
// Ports: rx_* from neighbours, tx_* to neighbours, inj_* local inject,
// ej_* local eject, err_ovf sticky overflow flag.
module tile_dim_router_fifo
    import tile_noc_pkg::*;
#(
    parameter int DATA_W  = NOC_DATA_W,
    parameter int ADDR_W  = NOC_ADDR_W,
    parameter int SZ_W    = NOC_SZ_W,
    parameter int COORD_W = NOC_COORD_W,
    parameter int DIM     = 0,
    parameter int TILE_C  = 0,
    parameter int DEPTH   = 8,
    parameter int STARVE  = 4,
    localparam int FLIT_W = DATA_W + ADDR_W + SZ_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             rx_vld,
    input  logic [1:0][FLIT_W-1:0] rx_flit,
    output logic [1:0]             rx_stop,
    output logic [1:0]             tx_vld,
    output logic [1:0][FLIT_W-1:0] tx_flit,
    input  logic [1:0]             tx_stop,
    input  logic                   inj_vld,
    input  logic [FLIT_W-1:0]      inj_flit,
    output logic                   inj_rdy,
    output logic                   ej_vld,
    output logic [FLIT_W-1:0]      ej_flit,
    input  logic                   ej_rdy,
    output logic                   err_ovf
);

    // dest coordinate sits inside addr, which follows sz and expun
    localparam int DOFF = SZ_W + 1 + DIM * COORD_W;
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int SW   = $clog2(STARVE + 1);
    localparam logic [COORD_W-1:0] TILE  = COORD_W'(TILE_C);
    localparam logic [CW-1:0]      HIWAT = CW'(DEPTH - 2);
    localparam logic [SW-1:0]      SMAX  = SW'(STARVE);

    logic [1:0]              rx_ej;
    logic [1:0]              ps_push, ps_pop, ps_full, ps_empty;
    logic [1:0]              ej_push, ej_pop, ej_full, ej_empty;
    logic [1:0][CW-1:0]      ps_cnt, ej_cnt, ps_nxt, ej_nxt;
    logic [1:0][FLIT_W-1:0]  ps_head, ej_head, ej_din;
    logic [1:0][SW-1:0]      starve;
    logic [1:0]              inj_tgt, inj_gnt, inj_fire;
    logic [COORD_W-1:0]      inj_dest;
    logic [COORD_W:0]        inj_diff;
    logic                    inj_lb, lb_ok, ej_sel, ovf, rr;

    always_comb begin
        inj_dest   = inj_flit[DOFF +: COORD_W];
        // borrow of dest - TILE gives dest < TILE
        inj_diff   = {1'b0, inj_dest} - {1'b0, TILE};
        inj_lb     = inj_vld && !rst && (inj_dest == TILE);
        inj_tgt[0] = inj_vld && !rst && inj_diff[COORD_W];
        inj_tgt[1] = inj_vld && !rst && !inj_diff[COORD_W] && (inj_dest != TILE);

        for (int l = 0; l < 2; l++) begin
            rx_ej[l]    = rx_vld[l] && (rx_flit[l][DOFF +: COORD_W] == TILE);
            ps_push[l]  = rx_vld[l] && !rx_ej[l];
            inj_gnt[l]  = inj_tgt[l] && (ps_empty[l] || (starve[l] == SMAX));
            tx_vld[l]   = (!ps_empty[l] || inj_gnt[l]) && !tx_stop[l];
            tx_flit[l]  = inj_gnt[l] ? inj_flit : ps_head[l];
            inj_fire[l] = inj_gnt[l] && !tx_stop[l];
            ps_pop[l]   = tx_vld[l] && !inj_gnt[l];
        end

        // a through flit ejecting on lane 0 owns the eject 0 write port
        lb_ok      = !ej_full[0] && !rx_ej[0];
        inj_rdy    = inj_fire[0] || inj_fire[1] || (inj_lb && lb_ok);
        ej_push[0] = rx_ej[0] || (inj_lb && lb_ok);
        ej_din[0]  = rx_ej[0] ? rx_flit[0] : inj_flit;
        ej_push[1] = rx_ej[1];
        ej_din[1]  = rx_flit[1];

        ej_vld = !(ej_empty[0] && ej_empty[1]);
        ej_sel = ej_empty[0] || (!ej_empty[1] && rr);
        ej_flit = ej_head[ej_sel];
        ej_pop = '0;
        ej_pop[ej_sel] = ej_vld && ej_rdy;

        ovf = 1'b0;
        for (int l = 0; l < 2; l++) begin
            ps_nxt[l] = ps_cnt[l]
                      + CW'(ps_push[l] && (!ps_full[l] || ps_pop[l]))
                      - CW'(ps_pop[l]);
            ej_nxt[l] = ej_cnt[l]
                      + CW'(ej_push[l] && (!ej_full[l] || ej_pop[l]))
                      - CW'(ej_pop[l]);
            ovf |= (ps_push[l] && ps_full[l] && !ps_pop[l])
                || (ej_push[l] && ej_full[l] && !ej_pop[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_stop <= '0;
            starve  <= '0;
            rr      <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            err_ovf <= err_ovf | ovf;
            for (int l = 0; l < 2; l++) begin
                rx_stop[l] <= (ps_nxt[l] >= HIWAT) || (ej_nxt[l] >= HIWAT);
                if (inj_fire[l])
                    starve[l] <= '0;
                else if (inj_tgt[l] && ps_pop[l])
                    starve[l] <= starve[l] + 1'b1;
            end
            if (ej_vld && ej_rdy && !ej_empty[0] && !ej_empty[1])
                rr <= ~rr;
        end
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane
        tile_lane_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_pass (
            .clk   (clk),
            .rst   (rst),
            .push  (ps_push[l]),
            .din   (rx_flit[l]),
            .pop   (ps_pop[l]),
            .head  (ps_head[l]),
            .count (ps_cnt[l]),
            .full  (ps_full[l]),
            .empty (ps_empty[l])
        );

        tile_lane_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_ej (
            .clk   (clk),
            .rst   (rst),
            .push  (ej_push[l]),
            .din   (ej_din[l]),
            .pop   (ej_pop[l]),
            .head  (ej_head[l]),
            .count (ej_cnt[l]),
            .full  (ej_full[l]),
            .empty (ej_empty[l])
        );
    end

endmodule

// File: doc/tile_dim_router_fifo.md
# tile_dim_router_fifo

Per-tile, per-dimension router stage for the cache-line request mesh. Two opposing lanes carry flits along one row (X) or column (Y): lane 0 toward lower coordinates, lane 1 toward higher. Each lane buffers through-traffic, ejects flits addressed to this tile into per-lane eject queues, and merges local injections with a starvation-bounded arbiter. Credit-style registered stop signals guarantee no overflow between neighbouring tiles.

## Interface
- DATA_W, 592, cache-line payload bits (66×8 + ECC/meta).
- ADDR_W, 37, line address bits.
- SZ_W, 42, size/attribute field {shared, exclusive, phymsk}.
- COORD_W, 2, tile coordinate bits.
- DIM, 0, 0 = route on X (addr[COORD_W-1:0]), 1 = route on Y (addr[2*COORD_W-1:COORD_W]).
- TILE_C, 0, this tile's coordinate in DIM.
- DEPTH, 8, entries per FIFO; power of two, ≥4.
- STARVE, 4, consecutive pass-wins before injection is forced.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_vld  in  2  flit valid from neighbour, per lane.
- rx_flit  in  2×FLIT_W  incoming flits; FLIT_W = DATA_W+ADDR_W+SZ_W+1 (expun).
- rx_stop  out  2  registered backpressure to upstream neighbour.
- tx_vld  out  2  outgoing flit valid, per lane.
- tx_flit  out  2×FLIT_W  outgoing flits.
- tx_stop  in  2  registered backpressure from downstream neighbour.
- inj_vld  in  1  local injection request.
- inj_flit  in  FLIT_W  local flit.
- inj_rdy  out  1  injection accepted this cycle when inj_vld&&inj_rdy.
- ej_vld  out  1  eject flit available.
- ej_flit  out  FLIT_W  eject flit.
- ej_rdy  in  1  local consumer accepts.
- err_ovf  out  1  sticky: a write hit a full FIFO.

## Operation
- dest = flit.addr[DIM*COORD_W +: COORD_W], unsigned.
- rx lane L: dest==TILE_C → eject FIFO L; else → pass FIFO L. rx_vld is a write regardless of rx_stop; writing a full FIFO drops the flit and sets err_ovf.
- rx_stop[L] registered: asserted next cycle when post-update occupancy of pass L or eject L ≥ DEPTH-2.
- Injection target: dest<TILE_C → lane 0; dest>TILE_C → lane 1; dest==TILE_C → eject FIFO 0 (loopback).
- tx lane L mux: pass FIFO L head has priority. starve[L] counts cycles where injection targeted L, inj_vld=1 and pass won; at starve[L]==STARVE the injection wins, counter clears. Counter clears on any injection win.
- tx_vld[L] = (pass L nonempty or injection granted to L) && !tx_stop[L]. Fire = tx_vld[L]; pass head pops on fire when it was selected.
- Loopback: inj_rdy = !full(eject 0) && !(rx_vld[0] && rx dest==TILE_C) (rx wins).
- Eject: round-robin between eject FIFOs 0/1; rr pointer flips after each pop when both nonempty; with one nonempty it is served. Pop on ej_vld&&ej_rdy.

## Timing
- Reset: all FIFOs empty, rx_stop=0, tx_vld=0, ej_vld=0, starve=0, rr=0, err_ovf=0; inj_rdy combinational (≠0 only if tx_stop permits).
- rx → tx through pass FIFO: 1 cycle min (write at edge n, head visible n+1).
- rx → ej_vld: 1 cycle. Injection → tx: 0 cycles (combinational bypass).
- Simultaneous pop and write on a full FIFO: both succeed, no error.
- Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
- rst mid-traffic: contents discarded, outputs at reset values the following cycle.

## Structure
- Package tile_noc_pkg: flit struct (data, addr, sz, expun), FLIT_W, dest-extract function, DIM encodings.
- Sub-module tile_lane_fifo (DEPTH, WIDTH; push/pop/head/count/full/empty), instantiated 4× (2 pass, 2 eject).

## Test plan
- TILE_C=1, DIM=0: rx lane 1 flit addr[1:0]=1 at cycle 5 → ej_vld at 6, ej_flit equal; no tx.
- rx lane 1 addr[1:0]=3 → tx_vld[1] at next cycle, identical flit; tx_stop[1]=1 holds it, release after 3 cycles → one transfer.
- Pass FIFO 1 kept nonempty, inj_vld with dest 3 held → injection wins on the 5th cycle (STARVE=4), then pass resumes.
- Fill pass 0 to DEPTH-2=6 entries with tx_stop[0]=1 → rx_stop[0]=1 next cycle; 7th/8th writes accepted, 9th → err_ovf=1.
- Both eject FIFOs hold 3 flits, ej_rdy=1 → output order 0,1,0,1,0,1.
- Loopback inject dest==TILE_C same cycle as rx lane 0 eject → inj_rdy=0, rx flit ejected first; injection accepted next cycle.
